// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed seven-segment scan driver.
package seg_pkg;

   localparam logic [7:0] SEG_OFF = 8'hFF;

   typedef logic [0:0] seg_state_t;
   localparam seg_state_t BLANK = 1'b0;
   localparam seg_state_t DRIVE = 1'b1;

   // Active-low gfedcba glyphs; the low slice holds hex digit 0.
   localparam logic [15:0][6:0] SEG_HEX_TBL = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   assign seg = SEG_HEX_TBL[hex];

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver with double-buffered, frame-aligned loads.
// Define SEG_LZ_BLANK_EN to blank leading zeros on digits above digit 0.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int unsigned DIGITS    = 6,
   parameter int unsigned SCAN_DIV  = 50000,
   parameter int unsigned BLANK_CYC = 4
) (
   input  logic                  CLK,
   input  logic                  Reset_n,
   input  logic [4*DIGITS-1:0]   Data,
   input  logic [DIGITS-1:0]     Dp,
   input  logic                  Load,
   output logic                  Ready,
   output logic [7:0]            Segs,
   output logic [DIGITS-1:0]     En
);

   localparam int unsigned CNT_W = $clog2(SCAN_DIV);
   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   seg_state_t          state_q, state_d;
   logic [4*DIGITS-1:0] pend_data_q, act_data_q;
   logic [DIGITS-1:0]   pend_dp_q, act_dp_q;
   logic                pend_valid_q;
   logic [7:0]          segs_q, segs_d;
   logic [DIGITS-1:0]   en_q, en_d;
   logic                frame_end, accept, commit;
   logic [3:0]          nibble;
   logic [6:0]          glyph, glyph_shown;

   // Ready is simply "no load waiting for a frame boundary".
   assign Ready     = ~pend_valid_q;
   assign accept    = Load & ~pend_valid_q;
   assign frame_end = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
   assign commit    = frame_end & pend_valid_q;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      idx_d = idx_q;
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      state_d = (cnt_d < CNT_BLANK) ? BLANK : DRIVE;
   end

   assign nibble = act_data_q[{idx_q, 2'b00} +: 4];

   seg_hex_decode u_hex_decode (
      .hex (nibble),
      .seg (glyph)
   );

`ifdef SEG_LZ_BLANK_EN
   logic [DIGITS-1:0] zero_above;
   logic              run_zero;

   // zero_above[i]: nibble i and every higher nibble are zero.
   always_comb begin
      run_zero   = 1'b1;
      zero_above = '0;
      for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
         run_zero      = run_zero & (act_data_q[4*i +: 4] == 4'h0);
         zero_above[i] = run_zero;
      end
   end

   assign glyph_shown = ((idx_q != '0) && zero_above[idx_q] && !act_dp_q[idx_q]) ? 7'h7F
                                                                                  : glyph;
`else
   assign glyph_shown = glyph;
`endif

   always_comb begin
      segs_d = SEG_OFF;
      en_d   = '1;
      if (state_q == DRIVE) begin
         segs_d = {~act_dp_q[idx_q], glyph_shown};
         en_d   = ~(DIGITS'(1) << idx_q);
      end
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         state_q      <= BLANK;
         segs_q       <= SEG_OFF;
         en_q         <= '1;
         pend_data_q  <= '0;
         pend_dp_q    <= '0;
         pend_valid_q <= 1'b0;
         act_data_q   <= '0;
         act_dp_q     <= '0;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         state_q <= state_d;
         segs_q  <= segs_d;
         en_q    <= en_d;
         if (commit) begin
            act_data_q   <= pend_data_q;
            act_dp_q     <= pend_dp_q;
            pend_valid_q <= 1'b0;
         end else if (accept) begin
            pend_data_q  <= Data;
            pend_dp_q    <= Dp;
            pend_valid_q <= 1'b1;
         end
      end
   end

   assign Segs = segs_q;
   assign En   = en_q;

endmodule
